// File: rtl/alu_op_sequencer_if.sv
// Host-side byte stream and result port of the ALU command sequencer.
// The master side is the host/consumer; the slave side is the sequencer.
interface alu_op_sequencer_if;
  // Byte-serial command stream (opcode, then optional A and B bytes)
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  // Result channel
  logic [7:0] out_data;
  logic [3:0] out_flags;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_flags,
    input  out_err,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_flags,
    output out_err,
    output out_valid
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command sequencer feeding the 8-bit ALU. Collects an opcode byte and up to
// two operand bytes from the host, launches one ALU operation, waits for the
// completion strobe (with timeout) and returns result/flags on a valid/ready
// port. The last good result is kept in an accumulator for CHAIN opcodes.
module alu_op_sequencer #(
  parameter int unsigned TIMEOUT = 15  // max WAIT cycles, 1..255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  alu_op_sequencer_if.slave        host,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_op,
  output logic                     alu_start,
  input  logic                     alu_done,
  input  logic [7:0]               alu_result,
  input  logic [3:0]               alu_flags
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_GET_OP,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  // Decoded opcode byte; bits [5:4] of the host byte carry no meaning.
  typedef struct packed {
    logic       chain;  // A comes from the accumulator, no A byte
    logic       unary;  // no B byte, B is forced to zero
    logic [3:0] op;
  } opcode_t;

  state_e     state_q,     state_d;
  opcode_t    op_q,        op_d;
  logic [7:0] a_q,         a_d;
  logic [7:0] acc_q,       acc_d;
  logic [7:0] cnt_q,       cnt_d;
  logic [7:0] alu_a_q,     alu_a_d;
  logic [7:0] alu_b_q,     alu_b_d;
  logic [3:0] alu_op_q,    alu_op_d;
  logic       alu_start_q, alu_start_d;
  logic [7:0] out_data_q,  out_data_d;
  logic [3:0] out_flags_q, out_flags_d;
  logic       out_err_q,   out_err_d;
  logic       out_valid_q, out_valid_d;

  logic       in_ready_w;
  logic       accept;
  logic       launch;
  logic       unused_in_bits;

  assign unused_in_bits = ^host.in_data[5:4];

  // Next-state logic: byte collection, launch, wait/timeout and response handshake.
  always_comb begin
    // NOTE: every _d starts from its _q value so that no branch leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = alu_start_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    launch      = 1'b0;

    in_ready_w = ena && ((state_q == S_GET_OP) || (state_q == S_GET_A) ||
                         (state_q == S_GET_B));
    accept     = host.in_valid && in_ready_w;

    // With ena low everything simply holds.
    if (ena) begin
      alu_start_d = 1'b0;

      unique case (state_q)
        S_GET_OP: begin
          if (accept) begin
            op_d = '{chain: host.in_data[7], unary: host.in_data[6],
                     op: host.in_data[3:0]};
            if (!host.in_data[7])      state_d = S_GET_A;
            else if (!host.in_data[6]) state_d = S_GET_B;
            else                       launch  = 1'b1;
          end
        end

        S_GET_A: begin
          if (accept) begin
            a_d = host.in_data;
            if (!op_q.unary) state_d = S_GET_B;
            else             launch  = 1'b1;
          end
        end

        S_GET_B: begin
          if (accept) launch = 1'b1;
        end

        S_ISSUE: begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end

        S_WAIT: begin
          // A done on the final counted cycle takes priority over the timeout.
          if (alu_done) begin
            out_data_d  = alu_result;
            acc_d       = alu_result;
            out_flags_d = alu_flags;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (cnt_q == TIMEOUT_CNT) begin
            out_data_d  = 8'h00;
            out_flags_d = 4'h0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        S_RESP: begin
          if (out_valid_q && host.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_GET_OP;
          end
        end

        default: state_d = S_GET_OP;
      endcase
    end

    // Operands are loaded only on the way into ISSUE so they stay stable
    // through WAIT and until the next launch. op_d/a_d already include a
    // byte accepted this cycle; the B byte is taken straight off the bus.
    if (launch) begin
      state_d     = S_ISSUE;
      alu_start_d = 1'b1;
      alu_op_d    = op_d.op;
      alu_a_d     = op_d.chain ? acc_q : a_d;
      alu_b_d     = op_d.unary ? 8'h00 : host.in_data;
    end
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (!rst_n) begin
      state_q     <= S_GET_OP;
      op_q        <= '0;
      a_q         <= 8'h00;
      acc_q       <= 8'h00;
      cnt_q       <= 8'd0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_op_q    <= 4'h0;
      alu_start_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_flags_q <= 4'h0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // A pending launch pulse is suppressed while the block is frozen.
  assign alu_start      = alu_start_q && ena;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;

  assign host.in_ready  = in_ready_w;
  assign host.out_data  = out_data_q;
  assign host.out_flags = out_flags_q;
  assign host.out_err   = out_err_q;
  assign host.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed scenarios followed by a
// randomized command stream. A behavioural ALU answers each launch after a
// chosen delay; expected results are predicted from the command stream.
module tb_alu_op_sequencer;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op, alu_flags;
  logic       alu_start, alu_done;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .host       (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] flags;
    logic       err;
  } resp_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } issue_t;

  resp_t  exp_q[$];
  issue_t iss_q[$];
  int     dly_q[$];          // 0 = ALU never answers
  logic [7:0] acc_m;         // reference accumulator

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic rand_ready = 1'b0;
  logic fixed_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural ALU: {flags, result}
  function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [7:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = {a[6:0], 1'b0};
      4'd6:    r = {1'b0, a[7:1]};
      default: r = a + b + {4'h0, op};
    endcase
    return {(r == 8'h00), r[7], ^r, (a < b), r};
  endfunction

  // Reference model: predicts what the launch and the result must be.
  task automatic push_expect(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b,
                             input int dly);
    logic [7:0]  ea, eb;
    logic [11:0] fr;
    resp_t       r;
    ea = opc[7] ? acc_m : a;
    eb = opc[6] ? 8'h00 : b;
    iss_q.push_back('{op: opc[3:0], a: ea, b: eb});
    dly_q.push_back(dly);
    fr = alu_model(opc[3:0], ea, eb);
    if (dly == 0 || dly > TIMEOUT + 1) begin
      r = '{data: 8'h00, flags: 4'h0, err: 1'b1};
    end else begin
      r = '{data: fr[7:0], flags: fr[11:8], err: 1'b0};
      acc_m = fr[7:0];
    end
    exp_q.push_back(r);
  endtask

  // Present one byte and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("byte_accepted", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_txn(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b,
                          input int dly, input int gap);
    push_expect(opc, a, b, dly);
    send_byte(opc);
    if (!opc[7]) begin
      idle(gap);
      send_byte(a);
    end
    if (!opc[6]) begin
      idle(gap);
      send_byte(b);
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    check("drain_results", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"},     32'(alu_a),         32'h00);
    check({tag, "_alu_b"},     32'(alu_b),         32'h00);
    check({tag, "_alu_op"},    32'(alu_op),        32'h0);
    check({tag, "_alu_start"}, 32'(alu_start),     32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'h00);
    check({tag, "_out_flags"}, 32'(bus.out_flags), 32'h0);
    check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Consumer ready driver (single writer of out_ready).
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end
  end

  // Behavioural ALU responder: checks the launch operands and answers after the queued delay.
  initial begin
    issue_t      e;
    int          d;
    logic [11:0] fr;
    alu_done   = 1'b0;
    alu_result = 8'h00;
    alu_flags  = 4'h0;
    forever begin
      @(negedge clk);
      if (rst_n && alu_start) begin
        if (iss_q.size() == 0) begin
          check("unexpected_alu_start", 32'(iss_q.size()), 32'd1);
        end else begin
          e = iss_q.pop_front();
          d = dly_q.pop_front();
          check("alu_op_at_start", 32'(alu_op), 32'(e.op));
          check("alu_a_at_start",  32'(alu_a),  32'(e.a));
          check("alu_b_at_start",  32'(alu_b),  32'(e.b));
          fr = alu_model(alu_op, alu_a, alu_b);
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1;
            alu_done   = 1'b1;
            alu_result = fr[7:0];
            alu_flags  = fr[11:8];
            @(posedge clk);
            #1;
            alu_done   = 1'b0;
            alu_result = 8'($urandom);
            alu_flags  = 4'($urandom);
          end
        end
      end
    end
  end

  // Monitor: pops and compares on every result handshake.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ena && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_data",  32'(bus.out_data),  32'(e.data));
          check("out_flags", 32'(bus.out_flags), 32'(e.flags));
          check("out_err",   32'(bus.out_err),   32'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] opc;
    int         r, dly;

    rst_n        = 1'b0;
    ena          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    acc_m        = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);
    check("in_ready_ena_low", 32'(bus.in_ready), 32'd0);
    ena = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    idle(1);

    // Basic ADD with launch/result timing
    send_txn(8'h00, 8'h12, 8'h34, 1, 0);
    @(negedge clk);
    check("basic_start_N+1", 32'(alu_start), 32'd1);
    check("basic_in_ready_issue", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("basic_start_one_cycle", 32'(alu_start), 32'd0);
    check("basic_valid_N+2", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("basic_valid_N+3", 32'(bus.out_valid), 32'd1);
    check("basic_data_0x46", 32'(bus.out_data), 32'h46);
    @(negedge clk);
    check("basic_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    check("basic_in_ready_back", 32'(bus.in_ready), 32'd1);
    drain();

    // Chain: A from accumulator (0x46) + 0x01
    send_txn(8'h80, 8'hFF, 8'h01, 1, 1);
    drain();

    // Unary + chain: launch right after the opcode, B = 0
    send_txn(8'hC0, 8'hFF, 8'hFF, 2, 0);
    @(negedge clk);
    check("unary_chain_start_N+1", 32'(alu_start), 32'd1);
    check("unary_chain_alu_b", 32'(alu_b), 32'h00);
    drain();

    // Timeout: ALU never answers
    send_txn(8'h02, 8'h5A, 8'h3C, 0, 0);
    repeat (17) @(negedge clk);
    check("timeout_valid_not_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("timeout_valid_W+16", 32'(bus.out_valid), 32'd1);
    check("timeout_err", 32'(bus.out_err), 32'd1);
    drain();
    // Accumulator must still hold 0x47
    send_txn(8'h80, 8'h00, 8'h00, 1, 0);
    drain();

    // Done on the last counted cycle wins; done one cycle later is ignored
    send_txn(8'h03, 8'h0C, 8'h30, TIMEOUT + 1, 0);
    drain();
    send_txn(8'h04, 8'hF0, 8'h0F, TIMEOUT + 2, 0);
    drain();

    // Backpressure in RESP
    fixed_ready = 1'b0;
    idle(1);
    send_txn(8'h01, 8'hA5, 8'h0F, 2, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("bp_valid_seen", 32'(seen), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_data_held", 32'(bus.out_data), 32'h96);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    fixed_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_at_handshake", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("bp_valid_dropped", 32'(bus.out_valid), 32'd0);
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    drain();

    // ena low for 4 cycles while in GET_A with a byte on offer
    push_expect(8'h01, 8'h90, 8'h10, 3);
    send_byte(8'h01);
    bus.in_data  = 8'h90;
    bus.in_valid = 1'b1;
    ena          = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ena_low_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    ena = 1'b1;
    send_byte(8'h90);
    send_byte(8'h10);
    drain();

    // Reset in WAIT aborts immediately and drops the pending result
    push_expect(8'h04, 8'h11, 8'h22, 0);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    acc_m = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    send_txn(8'h80, 8'h00, 8'h05, 1, 0);   // A must be the cleared accumulator
    drain();

    // Randomized stream with random consumer backpressure
    rand_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      opc = 8'($urandom);
      r   = $urandom_range(0, 9);
      if (r <= 5)      dly = r + 1;
      else if (r == 6) dly = TIMEOUT;
      else if (r == 7) dly = TIMEOUT + 1;
      else if (r == 8) dly = TIMEOUT + 2;
      else             dly = 0;
      send_txn(opc, 8'($urandom), 8'($urandom), dly, $urandom_range(0, 2));
    end
    drain();
    rand_ready = 1'b0;
    idle(4);
    check("issue_queue_empty", 32'(iss_q.size()), 32'd0);
    check("result_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
